// File: rtl/hs4_pkg.sv
// Shared definitions for the hs4 clocked-to-4-phase bridge: FSM encoding and default word width.
package hs4_pkg;

  localparam logic [1:0] HS_IDLE   = 2'd0;
  localparam logic [1:0] HS_REQ_HI = 2'd1;
  localparam logic [1:0] HS_REQ_LO = 2'd2;

  localparam int unsigned HS_WD = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = HS_IDLE,
    ST_REQ_HI = HS_REQ_HI,
    ST_REQ_LO = HS_REQ_LO
  } hs_state_e;

endpackage

// File: rtl/hs4_fifo.sv
// Power-of-two FIFO with (AW+1)-bit wrapping pointers; exposes head word, full/empty and occupancy.
module hs4_fifo
  import hs4_pkg::*;
#(
  parameter  int unsigned WD    = HS_WD,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [WD-1:0] wdata,
  input  logic          pop,
  output logic [WD-1:0] head_c,
  output logic          full_c,
  output logic          empty_c,
  output logic [AW:0]   level_c
);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [WD-1:0] mem_q [DEPTH];
  logic [WD-1:0] mem_d [DEPTH];

  // Pushes into a full FIFO are dropped so an entry is never overwritten.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full_c) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty_c) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign level_c = wr_ptr_q - rd_ptr_q;
  assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/hs4_tx_bridge.sv
// Buffers clocked words and emits them on a 4-phase bundled-data req/ack handshake.
// HS4_TX_ACK_SYNC_EN: pass ack through a two-flop synchroniser; otherwise ack is used directly.
module hs4_tx_bridge
  import hs4_pkg::*;
#(
  parameter  int unsigned WD    = HS_WD,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WD-1:0] in_data,
  output logic          req,
  input  logic          ack,
  output logic [WD-1:0] out_data,
  output logic [AW:0]   level
);

  hs_state_e     state_q, state_d;
  logic          req_q, req_d;
  logic [WD-1:0] out_data_q, out_data_d;
  logic          ack_s;
  logic          push_c, pop_c;
  logic [WD-1:0] head_c;
  logic          full_c, empty_c;
  logic [AW:0]   level_c;

`ifdef HS4_TX_ACK_SYNC_EN
  logic ack_meta_q, ack_meta_d;
  logic ack_sync_q, ack_sync_d;

  always_comb begin
    ack_meta_d = ack;
    ack_sync_d = ack_meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      ack_meta_q <= ack_meta_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  assign ack_s = ack_sync_q;
`else
  assign ack_s = ack;
`endif

  assign push_c = in_valid && !full_c;

  hs4_fifo #(.WD(WD), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_c),
    .wdata   (in_data),
    .pop     (pop_c),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .level_c (level_c)
  );

  // A new word is only launched once ack_s is low, so a stuck-high ack never starts a handshake.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    out_data_d = out_data_q;
    pop_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_c && !ack_s) begin
          out_data_d = head_c;
          pop_c      = 1'b1;
          req_d      = 1'b1;
          state_d    = ST_REQ_HI;
        end
      end
      ST_REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ST_REQ_LO;
        end
      end
      ST_REQ_LO: begin
        if (!ack_s) begin
          if (!empty_c) begin
            out_data_d = head_c;
            pop_c      = 1'b1;
            req_d      = 1'b1;
            state_d    = ST_REQ_HI;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      out_data_q <= out_data_d;
    end
  end

  assign req      = req_q;
  assign out_data = out_data_q;
  assign in_ready = !full_c;
  assign level    = level_c;

endmodule

// File: tb/tb_hs4_tx_bridge.sv
// Directed self-checking bench for hs4_tx_bridge with a background 4-phase consumer.
module tb_hs4_tx_bridge;

`ifdef HS4_TX_ACK_SYNC_EN
  localparam int ACK_LAT = 2;
  localparam int PERIOD  = 6;
`else
  localparam int ACK_LAT = 0;
  localparam int PERIOD  = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  wire        in_ready;
  wire        req;
  wire  [3:0] out_data;
  wire  [2:0] level;
  wire        ack;

  logic ack_r     = 1'b0;
  logic comb_mode = 1'b0;
  logic resp_en   = 1'b0;
  logic rand_dly  = 1'b0;
  int   fix_dly   = 0;

  int errors = 0;
  int checks = 0;
  logic [3:0] got_q[$];

  assign ack = comb_mode ? req : ack_r;

  always #5 clk = ~clk;

  hs4_tx_bridge #(.WD(4), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .req      (req),
    .ack      (ack),
    .out_data (out_data),
    .level    (level)
  );

  // Consumer: accept each req, record the word, check it holds until ack is dropped.
  initial begin : consumer
    logic [3:0] cw;
    logic bad;
    int d, n;
    forever begin
      @(negedge clk);
      if (resp_en && req === 1'b1 && !ack_r) begin
        cw  = out_data;
        bad = 1'b0;
        d   = rand_dly ? int'($urandom_range(0, 5)) : fix_dly;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (out_data !== cw) bad = 1'b1;
        end
        got_q.push_back(cw);
        ack_r = 1'b1;
        n = 0;
        while (req === 1'b1 && n < 200) begin
          @(negedge clk);
          n++;
          if (out_data !== cw) bad = 1'b1;
        end
        if (n >= 200) begin
          checks++; errors++;
          $display("FAIL consumer_req_fall_timeout req=%b required=0", req);
        end
        d = rand_dly ? int'($urandom_range(0, 5)) : fix_dly;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (out_data !== cw) bad = 1'b1;
        end
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL out_data_stable out_data=%h required=%h", out_data, cw);
        end
        ack_r = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog_timeout simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [3:0] d);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 100) begin
      acc = in_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout data=%h in_ready=%b required=1", d, in_ready);
    end
  endtask

  task automatic wait_req(input logic lvl, input string nm);
    int n = 0;
    while (req !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req !== lvl) begin
      errors++;
      $display("FAIL %s req=%b required=%b", nm, req, lvl);
    end
  endtask

  task automatic wait_got(input int n_exp, input string nm);
    int n = 0;
    while (got_q.size() < n_exp && n < 1500) begin
      @(negedge clk);
      n++;
    end
    repeat (12) @(negedge clk);
    checks++;
    if (got_q.size() != n_exp) begin
      errors++;
      $display("FAIL %s delivered=%0d required=%0d", nm, got_q.size(), n_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0;
    repeat (2) @(negedge clk);
    checks++; if (req !== 1'b0)      begin errors++; $display("FAIL reset_req req=%b required=0", req); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data out_data=%h required=0", out_data); end
    checks++; if (level !== 3'd0)    begin errors++; $display("FAIL reset_level level=%0d required=0", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready in_ready=%b required=1", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    got_q.delete();
    resp_en = 1'b1; fix_dly = 1; rand_dly = 1'b0;
    push(4'hA);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_req_early req=%b required=0", req); end
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || out_data !== 4'hA) begin
      errors++; $display("FAIL single_req_rise req=%b out_data=%h required req=1 out_data=a", req, out_data);
    end
    wait_got(1, "single_count");
    repeat (10) @(negedge clk);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 4'hA) begin
      errors++; $display("FAIL single_word delivered=%0d required=1 word=a", got_q.size());
    end
    resp_en = 1'b0;
  endtask

  task automatic test_fill();
    logic ok = 1'b1;
    got_q.delete();
    resp_en = 1'b0;
    for (int i = 1; i <= 5; i++) push(4'(i));
    checks++; if (level !== 3'd4)    begin errors++; $display("FAIL fill_level level=%0d required=4", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready in_ready=%b required=0", in_ready); end
    checks++;
    if (req !== 1'b1 || out_data !== 4'h1) begin
      errors++; $display("FAIL fill_head req=%b out_data=%h required req=1 out_data=1", req, out_data);
    end
    in_valid = 1'b1; in_data = 4'h6;
    repeat (3) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || level !== 3'd4) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL fill_push_blocked level=%0d in_ready=%b required level=4 in_ready=0", level, in_ready); end
    fix_dly = 0;
    resp_en = 1'b1;
    push(4'h6);
    wait_got(6, "fill_count");
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== 4'(i + 1)) begin
        errors++; $display("FAIL fill_order idx=%0d got=%h required=%h", i, got_q[i], 4'(i + 1));
      end
    end
    resp_en = 1'b0;
  endtask

  task automatic test_simul();
    logic [3:0] exp_w [5] = '{4'h2, 4'h3, 4'h7, 4'hC, 4'hD};
    got_q.delete();
    resp_en = 1'b0;
    for (int i = 0; i < 4; i++) push(4'(i));
    repeat (2) @(negedge clk);
    checks++;
    if (level !== 3'd3 || req !== 1'b1 || out_data !== 4'h0) begin
      errors++; $display("FAIL simul_setup level=%0d req=%b out_data=%h required 3/1/0", level, req, out_data);
    end
    ack_r = 1'b1;
    wait_req(1'b0, "simul_req_fall");
    ack_r = 1'b0;
    repeat (ACK_LAT) @(negedge clk);
    in_valid = 1'b1; in_data = 4'h7;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (req !== 1'b1 || out_data !== 4'h1 || level !== 3'd3) begin
      errors++; $display("FAIL simul_push_pop req=%b out_data=%h level=%0d required 1/1/3", req, out_data, level);
    end
    push(4'hC);
    in_valid = 1'b1; in_data = 4'hD;
    @(negedge clk);
    checks++;
    if (level !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL simul_full level=%0d in_ready=%b required 4/0", level, in_ready);
    end
    ack_r = 1'b1;
    wait_req(1'b0, "simul_full_req_fall");
    ack_r = 1'b0;
    wait_req(1'b1, "simul_full_req_rise");
    checks++;
    if (level !== 3'd3 || in_ready !== 1'b1) begin
      errors++; $display("FAIL simul_ready_registered level=%0d in_ready=%b required 3/1", level, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (level !== 3'd4) begin errors++; $display("FAIL simul_refill level=%0d required=4", level); end
    fix_dly = 0;
    resp_en = 1'b1;
    wait_got(5, "simul_count");
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_w[i]) begin
        errors++; $display("FAIL simul_order idx=%0d got=%h required=%h", i, got_q[i], exp_w[i]);
      end
    end
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL simul_drained level=%0d required=0", level); end
    resp_en = 1'b0;
  endtask

  task automatic test_wrap();
    got_q.delete();
    rand_dly = 1'b1;
    resp_en  = 1'b1;
    for (int i = 0; i < 20; i++) push(4'(i % 4));
    wait_got(20, "wrap_count");
    for (int i = 0; i < 20 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== 4'(i % 4)) begin
        errors++; $display("FAIL wrap_order idx=%0d got=%h required=%h", i, got_q[i], 4'(i % 4));
      end
    end
    checks++;
    if (level !== 3'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL wrap_level level=%0d in_ready=%b required 0/1", level, in_ready);
    end
    resp_en  = 1'b0;
    rand_dly = 1'b0;
  endtask

  task automatic test_period();
    int rt [3];
    logic [3:0] rd [3];
    int nr = 0;
    logic [3:0] exp_w [3] = '{4'hA, 4'h5, 4'h3};
    resp_en   = 1'b0;
    comb_mode = 1'b1;
    fork
      begin
        push(4'hA); push(4'h5); push(4'h3);
      end
      begin
        logic prev;
        prev = req;
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          if (req === 1'b1 && prev === 1'b0 && nr < 3) begin
            rt[nr] = c; rd[nr] = out_data; nr++;
          end
          prev = req;
        end
      end
    join
    comb_mode = 1'b0;
    checks++;
    if (nr != 3) begin
      errors++; $display("FAIL period_count handshakes=%0d required=3", nr);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rt[i] - rt[i-1] != PERIOD) begin
          errors++; $display("FAIL period_cycles idx=%0d period=%0d required=%0d", i, rt[i] - rt[i-1], PERIOD);
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rd[i] !== exp_w[i]) begin
          errors++; $display("FAIL period_data idx=%0d got=%h required=%h", i, rd[i], exp_w[i]);
        end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic ok = 1'b1;
    resp_en = 1'b0;
    ack_r   = 1'b0;
    push(4'hE);
    @(negedge clk);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL rstmid_req_hi req=%b required=1", req); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req !== 1'b0 || level !== 3'd0 || out_data !== 4'h0) begin
      errors++; $display("FAIL rstmid_async req=%b level=%0d out_data=%h required 0/0/0", req, level, out_data);
    end
    ack_r = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push(4'h6);
    repeat (6) begin
      @(negedge clk);
      if (req !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_ack_held req=%b required=0", req); end
    checks++;
    if (level !== 3'd1) begin errors++; $display("FAIL rstmid_level level=%0d required=1", level); end
    ack_r = 1'b0;
    wait_req(1'b1, "rstmid_req_after_ack_low");
    checks++;
    if (out_data !== 4'h6) begin errors++; $display("FAIL rstmid_data out_data=%h required=6", out_data); end
    ack_r = 1'b1;
    wait_req(1'b0, "rstmid_req_fall");
    ack_r = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_simul();
    test_wrap();
    test_period();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
